// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and elaboration helpers for sync_fifo.
//   DEFAULT_DATA_WIDTH / DEFAULT_DEPTH : default geometry (8 x 8)
//   is_pow2()                          : true when n is a positive power of two
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x DATA_WIDTH register array for sync_fifo.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears every entry)
//   write_en     store write_data at write_addr on the rising edge
//   write_addr   write index
//   write_data   word to store
//   read_addr    read index (asynchronous read)
//   read_data    mem[read_addr], combinational
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock parametrised FIFO with occupancy count, threshold
// flags and sticky overflow/underflow errors.
// Build option: define SYNC_FIFO_FWFT_EN for first-word fall-through reads
// (head word shown combinationally, read_enable pops it); otherwise reads are
// registered (popped word appears one cycle after the accepting edge).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   write_data/enable write port
//   read_enable       pop request
//   err_clear         clears overflow/underflow at the next edge
//   read_data/valid   read port
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow                             sticky error flags
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int DEPTH              = DEFAULT_DEPTH,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter int ADDR_WIDTH         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic                  err_clear,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] FULL_LV = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LV   = (ADDR_WIDTH + 1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_LV   = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_LEVEL);

  // Extra MSB on each pointer is the wrap bit: equal low bits with differing
  // MSBs means full, so the plain difference gives 0..DEPTH.
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] head_data;

  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == FULL_LV);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_LV);
  assign almost_empty = (count <= AE_LV);

  // Accepts use the pre-edge flags, so a pop never makes room for a push in
  // the same cycle.
  assign wr_accept = write_enable & ~full;
  assign rd_accept = read_enable & ~empty;

  sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .write_en  (wr_accept),
    .write_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .write_data(write_data),
    .read_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .read_data (head_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A fresh error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (write_enable & full)  | (overflow  & ~err_clear);
      underflow <= (read_enable  & empty) | (underflow & ~err_clear);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign read_data  = head_data;
  assign read_valid = ~empty;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= rd_accept;
      if (rd_accept) read_data <= head_data;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo (default 8 x 8 geometry),
// valid for both read-mode builds.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AF = DP - 2;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] write_data;
  logic          write_enable, read_enable, err_clear;
  logic [DW-1:0] read_data;
  logic          read_valid, full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a queue holding the FIFO contents plus error/read state.
  logic [7:0] q[$];
  bit         m_ov, m_un, m_rv;
  logic [7:0] m_rd;

  typedef struct {
    bit         we;
    logic [7:0] wd;
    bit         re;
    bit         ec;
    int         cnt;
    bit         full;
    bit         empty;
    bit         ov;
    bit         un;
    bit         cp;
    logic [7:0] pop;
  } vec_t;

  vec_t tv[$];

  sync_fifo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_data  (write_data),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .err_clear   (err_clear),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 0;
    m_un = 0;
    m_rv = 0;
    m_rd = '0;
  endtask

  task automatic model_compare();
    chk("count", count, q.size());
    chk("full", full, q.size() == DP);
    chk("empty", empty, q.size() == 0);
    chk("almost_full", almost_full, q.size() >= AF);
    chk("almost_empty", almost_empty, q.size() <= AE);
    chk("overflow", overflow, m_ov);
    chk("underflow", underflow, m_un);
`ifdef SYNC_FIFO_FWFT_EN
    chk("read_valid", read_valid, q.size() != 0);
    if (q.size() != 0) chk("read_data", read_data, q[0]);
`else
    chk("read_valid", read_valid, m_rv);
    chk("read_data", read_data, m_rd);
`endif
  endtask

  // One clock cycle: apply inputs, advance the model, compare after the edge.
  // cp/ep optionally name the word this cycle's read must deliver.
  task automatic step(input bit we, input logic [7:0] wd, input bit re, input bit ec,
                      input bit cp, input logic [7:0] ep);
    bit is_full, is_empty;
    write_enable = we;
    write_data   = wd;
    read_enable  = re;
    err_clear    = ec;
    #1;
`ifdef SYNC_FIFO_FWFT_EN
    if (cp) chk("pop_word", read_data, ep);
`endif
    is_full  = (q.size() == DP);
    is_empty = (q.size() == 0);
    m_rv = 0;
    if (re && !is_empty) begin
      m_rd = q.pop_front();
      m_rv = 1;
    end
    if (we && !is_full) q.push_back(wd);
    m_ov = (we && is_full) || (m_ov && !ec);
    m_un = (re && is_empty) || (m_un && !ec);
    @(posedge clk);
    #1;
`ifndef SYNC_FIFO_FWFT_EN
    if (cp) chk("pop_word", read_data, ep);
`endif
    model_compare();
  endtask

  function automatic vec_t mk(bit we, logic [7:0] wd, bit re, bit ec, int cnt,
                              bit f, bit e, bit ov, bit un, bit cp, logic [7:0] pop);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re; v.ec = ec; v.cnt = cnt;
    v.full = f; v.empty = e; v.ov = ov; v.un = un; v.cp = cp; v.pop = pop;
    return v;
  endfunction

  initial begin
    // Directed table: fill, overflow, clear, drain, underflow, read+write on empty.
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(1, 8'(i + 1), 0, 0, i + 1, i == 7, 0, 0, 0, 0, 8'h00));
    tv.push_back(mk(1, 8'hAA, 0, 0, 8, 1, 0, 1, 0, 0, 8'h00));
    tv.push_back(mk(0, 8'h00, 0, 1, 8, 1, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(0, 8'h00, 1, 0, 7 - i, 0, i == 7, 0, 0, 1, 8'(i + 1)));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 0, 8'h00));
    tv.push_back(mk(1, 8'h55, 1, 0, 1, 0, 0, 0, 1, 0, 8'h00));
    tv.push_back(mk(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0, 8'h00));
    tv.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 8'h55));

    rst_n = 1'b0;
    write_enable = 0; read_enable = 0; err_clear = 0; write_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_read_valid", read_valid, 0);
    chk("rst_read_data", read_data, 0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].we, tv[i].wd, tv[i].re, tv[i].ec, tv[i].cp, tv[i].pop);
      chk($sformatf("tv%0d_count", i), count, tv[i].cnt);
      chk($sformatf("tv%0d_full", i), full, tv[i].full);
      chk($sformatf("tv%0d_empty", i), empty, tv[i].empty);
      chk($sformatf("tv%0d_overflow", i), overflow, tv[i].ov);
      chk($sformatf("tv%0d_underflow", i), underflow, tv[i].un);
    end

    // Steady state at 4 entries with simultaneous read and write.
    for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(8'h14 + i), 1, 0, 1, 8'(8'h10 + i));
      chk("steady_count", count, 4);
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 1, 8'(8'h24 + i));

    // Threshold flags on the way up to 6 and back down to 2.
    for (int i = 1; i <= 6; i++) begin
      step(1, 8'(8'h60 + i), 0, 0, 0, 8'h00);
      chk("af_rise", almost_full, i >= 6);
    end
    for (int i = 5; i >= 2; i--) begin
      step(0, 8'h00, 1, 0, 0, 8'h00);
      chk("ae_fall", almost_empty, i <= 2);
    end

    // Randomised traffic in phases biased toward filling, draining, mixing.
    for (int i = 0; i < 400; i++) begin
      int wp, rp;
      case (i / 100)
        0: begin wp = 80; rp = 25; end
        1: begin wp = 20; rp = 80; end
        default: begin wp = 55; rp = 55; end
      endcase
      step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 99) < 6, 0, 8'h00);
    end

    // Asynchronous reset between edges while holding data.
    while (q.size() != 0) step(0, 8'h00, 1, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC1 + i), 0, 0, 0, 8'h00);
    chk("pre_rst_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_empty", empty, 1);
    chk("async_rst_count", count, 0);
    chk("async_rst_read_valid", read_valid, 0);
    chk("async_rst_read_data", read_data, 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    step(0, 8'h00, 0, 0, 0, 8'h00);
    step(1, 8'h3C, 0, 0, 0, 8'h00);
    step(0, 8'h00, 1, 0, 1, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the successor to the fixed 8×8 FIFO memory. Width, depth and thresholds are configurable. It adds full/empty/almost flags, an occupancy count and sticky overflow/underflow error flags. The read port is either registered or first-word fall-through, selected at compile time. It sits between same-clock producer and consumer blocks and replaces ad-hoc 8-entry buffers.

## Interface
- DATA_WIDTH, 8, bits per entry
- DEPTH, 8, entries; power of two, ≥ 2
- ALMOST_FULL_LEVEL, DEPTH-2, almost_full asserts when count ≥ this
- ALMOST_EMPTY_LEVEL, 2, almost_empty asserts when count ≤ this
- ADDR_WIDTH, $clog2(DEPTH), derived; do not override
- clk  in  1  the block's single clock
- rst_n  in  1  reset; asynchronous and active-low
- write_data  in  DATA_WIDTH  write word
- write_enable  in  1  write request
- read_enable  in  1  read/pop request
- err_clear  in  1  clears overflow/underflow
- read_data  out  DATA_WIDTH  read word
- read_valid  out  1  read_data holds a popped or head word
- full, empty  out  1  occupancy flags
- almost_full, almost_empty  out  1  threshold flags
- count  out  ADDR_WIDTH+1  entries held, 0..DEPTH
- overflow, underflow  out  1  sticky error flags

## Operation
- Storage: DEPTH × DATA_WIDTH register array, cleared to 0 on reset.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits each.
  - The low ADDR_WIDTH bits index the array.
  - The MSB is the wrap bit, so pointers wrap naturally mod 2·DEPTH.
  - count = wr_ptr − rd_ptr, mod 2^(ADDR_WIDTH+1).
- Write accept = write_enable & !full. On an accepted write: the word is stored at wr_ptr and wr_ptr increments.
- Read accept = read_enable & !empty. On an accepted read, rd_ptr increments.
- Accept rules are evaluated on pre-edge flags. A simultaneous read never frees space for a write in the same cycle.
- Simultaneous accepted read and write: count unchanged; both pointers advance.
- Write while full: data dropped, pointers unchanged, overflow ← 1.
- Read while empty: rd_ptr unchanged, read_data unchanged, underflow ← 1.
- Error flags hold until err_clear, which clears them at the next edge. If a new error occurs in the same cycle as err_clear, the set wins.
- Flags are decoded from the registered pointers:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ ALMOST_FULL_LEVEL)
  - almost_empty = (count ≤ ALMOST_EMPTY_LEVEL)

## Timing
- Reset values:
  - read_data = 0, read_valid = 0, count = 0
  - empty = 1, almost_empty = 1
  - full = 0, almost_full = 0, overflow = 0, underflow = 0
- Pointer, count and flag updates are visible the cycle after the accepting edge.
- Registered mode: an accepted read at edge N presents the head word on read_data, with read_valid = 1 for one cycle, after edge N. read_data holds its value otherwise.
- Write-to-read: a word written at edge N can be accepted for read at edge N+1 at the earliest.
- Reset mid-operation: all contents and pointers discard immediately, asynchronously. Outputs go to reset values without waiting for a clock edge.

## Configuration
- SYNC_FIFO_FWFT_EN defined (first-word fall-through):
  - read_data = mem[rd_ptr] combinationally; read_valid = !empty.
  - read_enable acknowledges and pops the word already shown.
  - Zero read latency.
- SYNC_FIFO_FWFT_EN undefined: registered read mode as described under Timing.
- All other behaviour is identical in both modes.

## Structure
- Package fifo_pkg holds:
  - the default DATA_WIDTH and DEPTH constants
  - a function checking that DEPTH is a power of two, used in an elaboration-time assertion
- Sub-module sync_fifo_ram holds the storage array:
  - one write port, one asynchronous read port
  - array reset on rst_n
- Pointer, flag and error logic lives in sync_fifo.

## Test plan
- Default parameters: write 0x01..0x08 over 8 cycles, then read 8 → data returned 0x01..0x08 in order; full = 1 after the 8th write; empty = 1 after the 8th read; count goes 0→8→0.
- Full FIFO, write 0xAA → overflow = 1; count stays 8; the next 8 reads return no 0xAA. Pulse err_clear → overflow = 0 next cycle.
- Empty FIFO, read_enable = 1 → underflow = 1, read_valid = 0, read_data unchanged. Same cycle with write_enable = 1 and data 0x55 → count = 1.
- 4 entries held, simultaneous read and write for 20 cycles with incrementing data → count stays 4; pointers wrap at least twice; output sequence is intact.
- Fill to 6 → almost_full = 1 at count 6; drain to 2 → almost_empty = 1 at count 2.
- Write 3 entries, assert rst_n = 0 mid-cycle → empty = 1 and count = 0 immediately, before the next clock edge. Run in both SYNC_FIFO_FWFT_EN builds.
